// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Segment patterns are ordered g..a and are active-low.
package seg_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} seg_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-data load handshake between the result producer and the scan controller.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic                      load_ack;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]     dp_in;

    modport master (output load, data_in, dp_in, input load_ack);
    modport slave  (input load, data_in, dp_in, output load_ack);
endinterface

// File: rtl/slot_timer.sv
// Loadable down-counter used to time both the lit and the blanking slots.
module slot_timer #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         start,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic         tc_next
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst)
            cnt_q <= '0;
        else if (start)
            cnt_q <= load_val;
        else if (clr)
            cnt_q <= '0;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign tc = (cnt_q == '0);
    // Lets the owner register a strobe that lines up with the terminal cycle.
    assign tc_next = start ? (load_val == '0) : (cnt_q == W'(1));
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes one segment bus over NUM_DIGITS common-anode digits with
// anti-ghost blanking; new display data is only applied at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  en,
    seg_scan_ctrl_if.slave        bus,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame_done
);
    localparam int CNT_W = $clog2(max_int(ON_CYCLES, BLANK_CYCLES) + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    seg_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    load_ack_q;
    logic                    capture, wrap, last_slot_d;
    logic                    tmr_start, tmr_clr, tmr_tc, tmr_tc_next;
    logic [CNT_W-1:0]        tmr_load;
    logic [NUM_DIGITS-1:0]   an_n_d;
    logic [6:0]              seg_n_d;
    logic                    dp_n_d, frame_done_d;

    slot_timer #(.W(CNT_W)) u_slot_timer (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (tmr_start),
        .clr      (tmr_clr),
        .load_val (tmr_load),
        .tc       (tmr_tc),
        .tc_next  (tmr_tc_next)
    );

    assign idx_inc = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    assign wrap    = (idx_q == LAST_IDX) && tmr_tc;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmr_start = 1'b0;
        tmr_clr   = 1'b0;
        tmr_load  = ON_LOAD;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Held load would otherwise re-capture while the ack is visible.
                capture = bus.load && !load_ack_q;
                if (en) begin
                    state_d   = SHOW;
                    idx_d     = '0;
                    tmr_start = 1'b1;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    tmr_start = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        idx_d   = idx_inc;
                        capture = wrap && bus.load;
                    end else begin
                        state_d  = BLANK;
                        tmr_load = BLANK_LOAD;
                    end
                end
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_d   = SHOW;
                    idx_d     = idx_inc;
                    tmr_start = 1'b1;
                    capture   = wrap && bus.load;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from next-state values so anode and segments move together.
    always_comb begin
        shadow_data_d = capture ? bus.data_in : shadow_data_q;
        shadow_dp_d   = capture ? bus.dp_in   : shadow_dp_q;
        last_slot_d   = (BLANK_CYCLES == 0) ? (state_d == SHOW) : (state_d == BLANK);
        frame_done_d  = last_slot_d && (idx_d == LAST_IDX) && tmr_tc_next;
        an_n_d        = '1;
        seg_n_d       = SEG_OFF;
        dp_n_d        = 1'b1;
        if (state_d == SHOW) begin
            an_n_d[idx_d] = 1'b0;
            seg_n_d       = hex_to_seg_n(shadow_data_d[4*idx_d +: 4]);
            dp_n_d        = ~shadow_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            load_ack_q    <= 1'b0;
            an_n          <= '1;
            seg_n         <= SEG_OFF;
            dp_n          <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            load_ack_q    <= capture;
            an_n          <= an_n_d;
            seg_n         <= seg_n_d;
            dp_n          <= dp_n_d;
            frame_done    <= frame_done_d;
        end
    end

    assign bus.load_ack = load_ack_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: one build with blanking, one without,
// both compared every cycle against a frame-position reference model.
module tb_seg_scan_ctrl;
    localparam int N  = 4;
    localparam int ON = 3;
    localparam int BL [2] = '{2, 0};
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk_in;
    logic        rst, en;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        ld [2];

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dpn_a, dpn_b, fd_a, fd_b;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus_a ();
    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus_b ();

    assign bus_a.load    = ld[0];
    assign bus_a.data_in = data;
    assign bus_a.dp_in   = dp;
    assign bus_b.load    = ld[1];
    assign bus_b.data_in = data;
    assign bus_b.dp_in   = dp;

    seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ON), .BLANK_CYCLES(2)) dut_a (
        .clk_in(clk_in), .rst(rst), .en(en), .bus(bus_a),
        .an_n(an_a), .seg_n(seg_a), .dp_n(dpn_a), .frame_done(fd_a));

    seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ON), .BLANK_CYCLES(0)) dut_b (
        .clk_in(clk_in), .rst(rst), .en(en), .bus(bus_b),
        .an_n(an_b), .seg_n(seg_b), .dp_n(dpn_b), .frame_done(fd_b));

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference: a running display is described only by its cycle position t in the scan.
    bit          run  [2];
    int          t    [2];
    logic [15:0] sd   [2];
    logic [3:0]  sp   [2];
    bit          mack [2];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        int frame;
        frame = N * (ON + BL[k]);
        if (rst) begin
            run[k] = 0; t[k] = 0; sd[k] = '0; sp[k] = '0; mack[k] = 0;
        end else if (!run[k]) begin
            if (ld[k] && !mack[k]) begin
                sd[k] = data; sp[k] = dp; mack[k] = 1;
            end else begin
                mack[k] = 0;
            end
            if (en) begin
                run[k] = 1; t[k] = 0;
            end
        end else if (!en) begin
            run[k] = 0; t[k] = 0; mack[k] = 0;
        end else begin
            if ((t[k] % frame) == frame - 1 && ld[k]) begin
                sd[k] = data; sp[k] = dp; mack[k] = 1;
            end else begin
                mack[k] = 0;
            end
            t[k] = t[k] + 1;
        end
    endtask

    task automatic check_inst(input int k, input logic [3:0] an, input logic [6:0] seg,
                              input logic dpn, input logic ack, input logic fd);
        int slot, frame, off, d;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        string      s;
        slot  = ON + BL[k];
        frame = N * slot;
        e_an  = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        if (run[k]) begin
            off = t[k] % slot;
            d   = (t[k] / slot) % N;
            if (off < ON) begin
                e_an  = ~(4'b0001 << d);
                e_seg = HEX[4'(sd[k] >> (4 * d))];
                e_dp  = ~sp[k][d];
            end
            e_fd = ((t[k] % frame) == frame - 1);
        end
        s = (k == 0) ? "blank2" : "blank0";
        check_val({s, ".an_n"},       32'(an),  32'(e_an));
        check_val({s, ".seg_n"},      32'(seg), 32'(e_seg));
        check_val({s, ".dp_n"},       32'(dpn), 32'(e_dp));
        check_val({s, ".load_ack"},   32'(ack), 32'(mack[k]));
        check_val({s, ".frame_done"}, 32'(fd),  32'(e_fd));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_step(0);
        model_step(1);
        @(negedge clk_in);
        cyc++;
        check_inst(0, an_a, seg_a, dpn_a, bus_a.load_ack, fd_a);
        check_inst(1, an_b, seg_b, dpn_b, bus_b.load_ack, fd_b);
        if (ld[0] && bus_a.load_ack) ld[0] = 1'b0;
        if (ld[1] && bus_b.load_ack) ld[1] = 1'b0;
    endtask

    task automatic req_load(input logic [15:0] d, input logic [3:0] p);
        data = d; dp = p; ld[0] = 1'b1; ld[1] = 1'b1;
    endtask

    initial begin
        bit found;
        rst = 1'b1; en = 1'b0; data = '0; dp = '0; ld[0] = 1'b0; ld[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            run[k] = 0; t[k] = 0; sd[k] = '0; sp[k] = '0; mack[k] = 0;
        end
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();

        // Capture and start together, then a mid-frame load that must wait for the wrap.
        req_load(16'h1A80, 4'b0100);
        en = 1'b1;
        repeat (7) step();
        req_load(16'hFFFF, 4'b0000);
        repeat (40) step();

        // Drop enable during digit 2's lit slot, then restart from digit 0.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (run[0] && (t[0] % 20) >= 10 && (t[0] % 20) < 13) found = 1;
            else step();
        end
        check_val("reach_digit2_show", 32'(found), 32'd1);
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (30) step();

        // Reset during digit 3 blanking with a load pending; the load is abandoned.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (run[0] && (t[0] % 20) == 18) found = 1;
            else step();
        end
        check_val("reach_digit3_blank", 32'(found), 32'd1);
        req_load(16'h5A3C, 4'b1111);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld[0] = 1'b0; ld[1] = 1'b0;
        repeat (25) step();

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if (!ld[0] && !ld[1] && $urandom_range(0, 19) == 0)
                req_load(16'($urandom), 4'($urandom));
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared 7-segment segment bus across NUM_DIGITS common-anode digits of the adder's result display.
- Sequences each digit through an ON slot and a blanking (anti-ghost) slot using an internal strobe-based prescaler. No derived clocks; everything runs on clk_in.
- Accepts new display data through a load/ack handshake and applies it only at a frame boundary, so a frame never shows mixed old and new digits.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (≥2).
- ON_CYCLES, 50000: clk_in cycles each digit is lit (1 kHz digit rate at 50 MHz; ≥1).
- BLANK_CYCLES, 500: clk_in cycles all anodes are off between digits; 0 skips blanking.

Ports:
- clk_in  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scanning enable; 0 blanks the display
- data_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = bits 3:0)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- load  in  1  request to capture data_in/dp_in; held until load_ack
- load_ack  out  1  one-cycle pulse in the capture cycle
- an_n  out  NUM_DIGITS  anode selects, active-low, one-hot-low or all-high
- seg_n  out  7  segments g..a, active-low
- dp_n  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at end of the last digit's slot

Behaviour:
- Reset: an_n all 1, seg_n 7'h7F, dp_n 1, load_ack 0, frame_done 0, digit index 0, shadow data/dp 0, state IDLE, counter 0. All outputs are registered.
- States: IDLE, SHOW, BLANK.
- IDLE: all outputs off.
  - If load is high, capture immediately and pulse load_ack.
  - If en is high, go to SHOW with digit 0 and counter 0.
- SHOW: an_n[idx]=0, others 1. seg_n = hex decode of shadow nibble idx; dp_n = ~shadow_dp[idx].
  - Lasts exactly ON_CYCLES cycles (counter 0..ON_CYCLES-1).
  - Then go to BLANK, or directly to the next SHOW if BLANK_CYCLES=0.
- BLANK: an_n all 1, seg_n 7'h7F, dp_n 1, for exactly BLANK_CYCLES cycles. Then go to SHOW of the next digit.
- Digit advance: idx increments and wraps NUM_DIGITS-1→0.
- Wrap: frame_done pulses for one cycle. It is asserted on the last cycle of digit NUM_DIGITS-1's slot (the last BLANK cycle, or the last SHOW cycle if BLANK_CYCLES=0).
- Load while scanning: if load is high on the wrap cycle, the shadow registers take data_in/dp_in and load_ack pulses in that same cycle. Digit 0 of the next frame shows the new data.
  - load is ignored at all other times.
  - A load that rises mid-frame waits for the wrap.
- Simultaneous load and en rising in IDLE: capture and start in the same cycle. Digit 0 shows the new data.
- en falls in SHOW or BLANK: next cycle goes to IDLE with outputs off, idx and counter reset to 0. No frame_done.
- Reset mid-frame: returns to reset values on the next edge regardless of state. A pending load is dropped.
- Hex decode covers 0-F, segment order g..a, active-low, e.g.:
  - 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E.
- Counter width is $clog2(max(ON_CYCLES, BLANK_CYCLES)+1). Index width is $clog2(NUM_DIGITS). Counter comparisons use full width with no truncation.
- Glitch rule: anode and segment changes occur on the same edge. An anode is never low while seg_n carries another digit's value.

Decomposition:
- Package seg_pkg:
  - state enum {IDLE, SHOW, BLANK}
  - SEG_OFF constant 7'h7F
  - function hex_to_seg_n(4-bit) → 7-bit active-low pattern
- Sub-module slot_timer: loadable down-counter with start and terminal-count strobe, parameterised width. It is reused for the ON and BLANK slots.

Test Plan (NUM_DIGITS=4, ON_CYCLES=3, BLANK_CYCLES=2):
- Reset high for 2 cycles, then low with en=0 → all outputs at reset values, no load_ack, no frame_done for 20 cycles.
- load=1 with data_in=16'h1A80, dp_in=4'b0100, en=1 in IDLE → load_ack pulse in the first cycle.
  - Digit 0 shows 7'h40 for 3 cycles, then 2 cycles all off, then digit 1 shows 7'h00.
  - Digit 2 shows 7'h08 with dp_n=0; digit 3 shows 7'h79.
  - frame_done pulses every 20 cycles.
- Mid-frame load of 16'hFFFF during digit 1 → load held, no ack until the wrap cycle. Digit 2 and digit 3 of the current frame still show the old values; the next frame shows 7'h0E on all digits.
- en dropped during digit 2's SHOW → next cycle an_n=4'hF, seg_n=7'h7F. Re-enable restarts at digit 0.
- BLANK_CYCLES=0 build → digits back-to-back, 3 cycles each, frame_done every 12 cycles, an_n never all-high while en=1.
- rst asserted during BLANK of digit 3 with load high → next cycle reset values, no load_ack, shadow = 0.
